// File: rtl/apb4_master_bridge.sv
// Valid/ready request port to APB4 master bridge: one transfer in flight,
// registered APB and response outputs, optional wait-state timeout.
module apb4_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  input  logic [2:0]              req_prot,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic [DATA_WIDTH-1:0]   PRDATA
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN  = (TIMEOUT != 0);
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        wait_cnt, wait_cnt_nx;
  logic                    req_ready_nx, psel_nx, penable_nx, pwrite_nx;
  logic [ADDR_WIDTH-1:0]   paddr_nx;
  logic [DATA_WIDTH-1:0]   pwdata_nx, rsp_rdata_nx;
  logic [STRB_W-1:0]       pstrb_nx;
  logic [2:0]              pprot_nx;
  logic                    rsp_valid_nx, rsp_err_nx, rsp_timeout_nx;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      req_ready   <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      PPROT       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_cnt_nx;
      req_ready   <= req_ready_nx;
      PSEL        <= psel_nx;
      PENABLE     <= penable_nx;
      PWRITE      <= pwrite_nx;
      PADDR       <= paddr_nx;
      PWDATA      <= pwdata_nx;
      PSTRB       <= pstrb_nx;
      PPROT       <= pprot_nx;
      rsp_valid   <= rsp_valid_nx;
      rsp_rdata   <= rsp_rdata_nx;
      rsp_err     <= rsp_err_nx;
      rsp_timeout <= rsp_timeout_nx;
    end
  end

  // The APB address/data registers double as the request latch: they are
  // loaded on acceptance and so are already valid during SETUP.
  always_comb begin
    state_nx       = state;
    wait_cnt_nx    = wait_cnt;
    psel_nx        = 1'b0;
    penable_nx     = 1'b0;
    pwrite_nx      = PWRITE;
    paddr_nx       = PADDR;
    pwdata_nx      = PWDATA;
    pstrb_nx       = PSTRB;
    pprot_nx       = PPROT;
    rsp_valid_nx   = 1'b0;
    rsp_rdata_nx   = '0;
    rsp_err_nx     = 1'b0;
    rsp_timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_nx    = SETUP;
          wait_cnt_nx = '0;
          psel_nx     = 1'b1;
          pwrite_nx   = req_write;
          paddr_nx    = req_addr;
          pwdata_nx   = req_write ? req_wdata : PWDATA;
          pstrb_nx    = req_write ? req_strb : '0;
          pprot_nx    = req_prot;
        end
      end
      SETUP: begin
        state_nx   = ACCESS;
        psel_nx    = 1'b1;
        penable_nx = 1'b1;
      end
      ACCESS: begin
        psel_nx    = 1'b1;
        penable_nx = 1'b1;
        if (PREADY) begin
          state_nx     = IDLE;
          psel_nx      = 1'b0;
          penable_nx   = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = PSLVERR;
          rsp_rdata_nx = PWRITE ? '0 : PRDATA;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
          if (TO_EN && (32'(wait_cnt) + 32'd1 == TO_LIM)) begin
            state_nx       = IDLE;
            psel_nx        = 1'b0;
            penable_nx     = 1'b0;
            rsp_valid_nx   = 1'b1;
            rsp_err_nx     = 1'b1;
            rsp_timeout_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    req_ready_nx = (state_nx == IDLE);
  end
endmodule

// File: tb/tb_apb4_master_bridge.sv
// Directed bench for apb4_master_bridge: a transaction-timeline model is
// compared against the DUT every cycle, plus literal latency/data checks.
module tb_apb4_master_bridge;
  localparam int TO = 4;

  logic        PCLK = 1'b0, PRESETn = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic [2:0]  req_prot = '0;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;
  logic [31:0] PRDATA = '0;

  apb4_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave script for the request currently presented
  int          s_waits = 0;
  logic [31:0] s_rdata = '0;
  logic        s_err = 1'b0;

  // Transaction-level model: on acceptance the whole transfer timeline is known
  // (SETUP, then waits+1 ACCESS cycles or TO cycles if it times out).
  logic        m_busy, m_write, m_err, m_to;
  int          m_k, m_w, m_end;
  logic [31:0] m_rdata;
  logic        e_ready, e_psel, e_pen, e_pwrite, e_rv, e_rerr, e_rto;
  logic [31:0] e_paddr, e_pwdata, e_rdata;
  logic [3:0]  e_pstrb;
  logic [2:0]  e_pprot;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_busy <= 0; m_k <= 0; m_w <= 0; m_end <= 0; m_write <= 0; m_err <= 0; m_to <= 0; m_rdata <= 0;
      e_ready <= 0; e_psel <= 0; e_pen <= 0; e_pwrite <= 0; e_paddr <= 0; e_pwdata <= 0;
      e_pstrb <= 0; e_pprot <= 0; e_rv <= 0; e_rdata <= 0; e_rerr <= 0; e_rto <= 0;
    end else begin
      e_rv <= 0; e_rdata <= 0; e_rerr <= 0; e_rto <= 0;
      e_ready <= 1'b1;
      if (!m_busy) begin
        e_psel <= 0; e_pen <= 0;
        if (req_valid && e_ready) begin
          m_busy <= 1; m_k <= 0;
          m_write <= req_write; m_w <= s_waits; m_rdata <= s_rdata; m_err <= s_err;
          m_to  <= (s_waits >= TO);
          m_end <= (s_waits >= TO) ? TO + 1 : s_waits + 2;
          e_psel <= 1; e_ready <= 0;
          e_pwrite <= req_write; e_paddr <= req_addr; e_pprot <= req_prot;
          e_pstrb  <= req_write ? req_strb : 4'h0;
          if (req_write) e_pwdata <= req_wdata;
        end
      end else if (m_k + 1 == m_end) begin
        m_busy <= 0; e_psel <= 0; e_pen <= 0;
        e_rv <= 1; e_rerr <= m_to | m_err; e_rto <= m_to;
        e_rdata <= (m_to || m_write) ? 32'h0 : m_rdata;
      end else begin
        m_k <= m_k + 1; e_psel <= 1; e_pen <= 1; e_ready <= 0;
      end
    end
  end

  // Slave: ready once the scripted wait states are spent; junk otherwise.
  always @(negedge PCLK) begin
    if (m_busy && m_k >= 1 && m_k >= m_w + 1) begin
      PREADY <= 1'b1; PRDATA <= m_rdata; PSLVERR <= m_err;
    end else begin
      PREADY <= 1'b0; PRDATA <= $urandom; PSLVERR <= 1'b1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge PCLK) begin
    chk("req_ready", {31'b0, req_ready}, {31'b0, e_ready});
    chk("PSEL", {31'b0, PSEL}, {31'b0, e_psel});
    chk("PENABLE", {31'b0, PENABLE}, {31'b0, e_pen});
    chk("PWRITE", {31'b0, PWRITE}, {31'b0, e_pwrite});
    chk("PADDR", PADDR, e_paddr);
    chk("PWDATA", PWDATA, e_pwdata);
    chk("PSTRB", {28'b0, PSTRB}, {28'b0, e_pstrb});
    chk("PPROT", {29'b0, PPROT}, {29'b0, e_pprot});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_rv});
    if (e_rv) begin
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, e_rerr});
      chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e_rto});
    end
  end

  typedef struct { int c; logic [31:0] rdata; logic err; logic to; } rsp_t;
  rsp_t rsp_q[$];
  int   pen_cnt = 0;
  always @(negedge PCLK) begin
    if (rsp_valid) rsp_q.push_back('{cyc, rsp_rdata, rsp_err, rsp_timeout});
    if (PENABLE) pen_cnt <= pen_cnt + 1;
  end

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p, input int waits,
                        input logic [31:0] rd, input logic er, input bit drop, output int acc);
    bit got = 0;
    @(negedge PCLK);
    req_write = w; req_addr = a; req_wdata = d; req_strb = s; req_prot = p;
    s_waits = waits; s_rdata = rd; s_err = er; req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      if (i > 0) @(negedge PCLK);
      if (req_ready) begin
        acc = cyc; got = 1;
        @(posedge PCLK); #1;
        if (drop) req_valid = 1'b0;
        chk("setup_psel", {31'b0, PSEL}, 32'd1);
        chk("setup_penable", {31'b0, PENABLE}, 32'd0);
      end
    end
    if (!got) chk("accept_wait", 32'd0, 32'd1);
  endtask

  task automatic wait_rsps(input int n);
    for (int i = 0; i < 40 && rsp_q.size() < n; i++) begin
      @(negedge PCLK); #1;
    end
    chk("rsp_count", rsp_q.size(), n);
  endtask

  int a0, a1, a2;

  initial begin
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_psel", {31'b0, PSEL}, 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("ready_after_reset", {31'b0, req_ready}, 32'd1);

    // Write with zero wait states
    rsp_q.delete();
    do_req(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010, 0, 32'h12345678, 0, 1, a0);
    wait_rsps(1);
    if (rsp_q.size() > 0) begin
      chk("wr_latency", rsp_q[0].c - a0, 32'd3);
      chk("wr_err", {31'b0, rsp_q[0].err}, 32'd0);
      chk("wr_rdata", rsp_q[0].rdata, 32'd0);
    end

    // Read with two wait states; strobes must be forced low
    rsp_q.delete();
    do_req(0, 32'h20, 32'h55555555, 4'hF, 3'b001, 2, 32'hDEADBEEF, 0, 1, a0);
    wait_rsps(1);
    if (rsp_q.size() > 0) begin
      chk("rd_latency", rsp_q[0].c - a0, 32'd5);
      chk("rd_rdata", rsp_q[0].rdata, 32'hDEADBEEF);
    end
    chk("rd_pwdata_held", PWDATA, 32'hDEADBEEF);
    chk("rd_pstrb", {28'b0, PSTRB}, 32'd0);

    // Slave error on an out-of-range read
    rsp_q.delete();
    do_req(0, 32'h1000, 32'h0, 4'h0, 3'b000, 0, 32'hCAFEF00D, 1, 1, a0);
    wait_rsps(1);
    if (rsp_q.size() > 0) begin
      chk("slverr_err", {31'b0, rsp_q[0].err}, 32'd1);
      chk("slverr_to", {31'b0, rsp_q[0].to}, 32'd0);
      chk("slverr_latency", rsp_q[0].c - a0, 32'd3);
    end

    // Timeout: PREADY never rises
    rsp_q.delete();
    pen_cnt = 0;
    do_req(0, 32'h40, 32'h0, 4'h0, 3'b100, 100, 32'h0, 0, 1, a0);
    wait_rsps(1);
    if (rsp_q.size() > 0) begin
      chk("to_latency", rsp_q[0].c - a0, 32'd6);
      chk("to_err", {31'b0, rsp_q[0].err}, 32'd1);
      chk("to_flag", {31'b0, rsp_q[0].to}, 32'd1);
      chk("to_rdata", rsp_q[0].rdata, 32'd0);
    end
    chk("to_access_cycles", pen_cnt, 32'd4);

    // Back-to-back writes with req_valid held high
    rsp_q.delete();
    do_req(1, 32'h100, 32'hA, 4'h1, 3'b000, 0, 32'h0, 0, 0, a0);
    do_req(1, 32'h104, 32'hB, 4'h3, 3'b000, 0, 32'h0, 0, 0, a1);
    do_req(1, 32'h108, 32'hC, 4'h7, 3'b000, 0, 32'h0, 0, 1, a2);
    wait_rsps(3);
    chk("b2b_gap1", a1 - a0, 32'd3);
    chk("b2b_gap2", a2 - a1, 32'd3);
    if (rsp_q.size() == 3) begin
      chk("b2b_first", rsp_q[0].c - a0, 32'd3);
      chk("b2b_span", rsp_q[2].c - rsp_q[0].c, 32'd6);
    end

    // Reset during ACCESS
    rsp_q.delete();
    do_req(0, 32'h200, 32'h0, 4'h0, 3'b111, 100, 32'h0, 0, 1, a0);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("pre_rst_penable", {31'b0, PENABLE}, 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    chk("mid_rst_psel", {31'b0, PSEL}, 32'd0);
    chk("mid_rst_penable", {31'b0, PENABLE}, 32'd0);
    chk("mid_rst_paddr", PADDR, 32'd0);
    chk("mid_rst_pprot", {29'b0, PPROT}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("ready_after_mid_rst", {31'b0, req_ready}, 32'd1);
    repeat (8) @(negedge PCLK);
    #1;
    chk("no_rsp_after_rst", rsp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/apb4_master_bridge.md
# apb4_master_bridge

Converts a simple valid/ready request port into APB4 transfers and drives the APB4 slave memory (32-bit address, 32-bit data, 1024-word depth) that the slave VIP environment checks. It sits directly upstream of the slave: it owns PSEL/PENABLE sequencing, wait-state handling, PSTRB/PPROT generation and a wait-state timeout. It returns one response per request on a registered response port.

## Interface
- ADDR_WIDTH, 32, PADDR/req_addr width
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be 8, 16 or 32
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout
- PCLK  in  1  single clock, rising edge
- PRESETn  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  write data
- req_strb  in  DATA_WIDTH/8  write byte enables
- req_prot  in  3  protection attributes
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
- rsp_err  out  1  PSLVERR or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB4 control
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  DATA_WIDTH/8; PPROT  out  3
- PREADY, PSLVERR  in  1 each; PRDATA  in  DATA_WIDTH

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE: req_ready=1. On req_valid && req_ready, the bridge latches write, addr, wdata, strb and prot, then goes to SETUP.
- SETUP: PSEL=1, PENABLE=0. PADDR, PWRITE, PWDATA, PSTRB and PPROT are driven from the latch. Next state is always ACCESS.
- ACCESS: PSEL=1, PENABLE=1. All APB signals are held stable.
  - PREADY=1: capture PRDATA (reads only) and PSLVERR, then go to IDLE. The next cycle has rsp_valid=1.
  - PREADY=0: increment wait counter.
  - Counter reaches TIMEOUT (TIMEOUT≠0): abort to IDLE. The next cycle has rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Reads: PSTRB forced to 0 regardless of req_strb. PWDATA is held at its last value, not the new req_wdata.
- Writes: rsp_rdata=0. rsp_err=PSLVERR.
- PSLVERR is sampled only on the ACCESS cycle with PREADY=1 and ignored otherwise.
- Idle bus: PSEL=0, PENABLE=0. PADDR, PWRITE, PSTRB and PPROT hold their last values.
- Wait counter is cleared on entry to SETUP. Counter width is clog2(TIMEOUT+1).
- req_addr is forwarded unmodified; no alignment is applied. Out-of-range handling belongs to the slave.
- Requests are not accepted outside IDLE (req_ready=0). Only one transfer is outstanding; there is no buffering.

## Timing
- Reset (PRESETn low, asynchronous): state=IDLE and counter=0.
  - All outputs are 0, including req_ready, PSEL, PENABLE, PADDR, PWDATA, PSTRB, PPROT, rsp_*.
- req_ready rises on the first PCLK edge after PRESETn deasserts.
- Request accepted at edge N: SETUP in cycle N+1, ACCESS in cycle N+2.
- With PREADY=1 in the first ACCESS cycle, rsp_valid=1 and req_ready=1 in cycle N+3.
- Minimum of 3 cycles per transfer, and each wait state adds 1 cycle.
- Back-to-back: a request can be accepted in the same cycle rsp_valid is high. The next SETUP follows the next edge, so PSEL drops for one cycle between transfers.
- Timeout: abort after TIMEOUT consecutive PREADY=0 ACCESS cycles. PSEL and PENABLE are 0 on the following cycle.
- Reset mid-transfer: PSEL and PENABLE drop immediately. No response is produced for the in-flight request.
- rsp_valid is a single-cycle pulse with no backpressure; the consumer must always accept it.

## Test plan
- Write, PREADY tied high: addr=0x0000_0010, wdata=0xDEAD_BEEF, strb=0xF. Expect PSEL at N+1, PENABLE at N+2, PSTRB=0xF, PWRITE=1, rsp_valid at N+3 with rsp_err=0.
- Read with 2 wait states: PREADY low for 2 ACCESS cycles, then PRDATA=0xDEAD_BEEF. Expect PSTRB=0, rsp_rdata=0xDEAD_BEEF at N+5, and APB signals stable throughout ACCESS.
- PSLVERR: read of addr=0x0000_1000 (beyond depth 1024) with PREADY=1 and PSLVERR=1. Expect rsp_err=1, rsp_timeout=0.
- Timeout with TIMEOUT=4 and PREADY held 0. Expect exactly 4 ACCESS cycles, then PSEL=0, then rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Back-to-back: 3 writes with req_valid held high. Expect transfers every 3 cycles, one PSEL-low gap each, and 3 rsp_valid pulses in order.
- Reset asserted during ACCESS: expect all outputs 0 asynchronously, no rsp_valid, and req_ready=1 on the first edge after release.
